// File: rtl/seed_key_sequencer_if.sv
// Handshake and control bus between the SEED key-schedule sequencer and its host/datapath.
// The slave modport is the sequencer; the master modport is the side that drives start/abort/key bytes.
interface seed_key_sequencer_if;
    logic       start;
    logic       abort;
    logic [7:0] key_in;
    logic       key_valid;
    logic       key_ready;
    logic [7:0] key_byte;
    logic [4:0] main_counter;
    logic [4:0] round_counter;
    logic       sk_valid;
    logic [3:0] sk_round;
    logic [1:0] sk_index;
    logic       busy;
    logic       done;
    logic       key_err;

    modport master (
        output start, abort, key_in, key_valid,
        input  key_ready, key_byte, main_counter, round_counter,
        input  sk_valid, sk_round, sk_index, busy, done, key_err
    );

    modport slave (
        input  start, abort, key_in, key_valid,
        output key_ready, key_byte, main_counter, round_counter,
        output sk_valid, sk_round, sk_index, busy, done, key_err
    );
endinterface

// File: rtl/seed_key_sequencer.sv
// Control sequencer for the 8-bit serialized SEED key schedule: loads the 128-bit key,
// steps main/round counters through the 17-cycle phases and tags subkey bytes.
module seed_key_sequencer #(
    parameter int PHASE_LEN = 17,
    parameter int ROUNDS    = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    seed_key_sequencer_if.slave  bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    localparam logic [4:0] MAIN_LAST = 5'(PHASE_LEN - 1);
    localparam logic [4:0] KEY_LAST  = 5'd15;
    localparam logic [4:0] SK_LAST   = 5'd3;
    localparam logic [4:0] RUN_LAST  = 5'(ROUNDS - 1);
    localparam logic [4:0] DRAIN_RND = 5'(ROUNDS);

    logic [1:0] state_q, state_d;
    logic [4:0] main_q, main_d;
    logic [4:0] round_q, round_d;
    logic       key_err_q, key_err_d;

    logic       phase_end;
    logic       key_ready;
    logic       key_gap;
    logic       sk_valid;

    assign phase_end = (main_q == MAIN_LAST);
    assign key_ready = (state_q == ST_LOAD) && (main_q <= KEY_LAST);
    assign key_gap   = key_ready && !bus.key_valid;

    always_comb begin
        state_d   = state_q;
        main_d    = main_q;
        round_d   = round_q;
        key_err_d = key_err_q;
        // abort wins over everything, including a key gap in the same cycle
        if (bus.abort) begin
            state_d = ST_IDLE;
            main_d  = 5'd0;
            round_d = 5'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_d   = ST_LOAD;
                        main_d    = 5'd0;
                        round_d   = 5'd0;
                        key_err_d = 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (key_gap) begin
                        state_d   = ST_IDLE;
                        main_d    = 5'd0;
                        round_d   = 5'd0;
                        key_err_d = 1'b1;
                    end else if (phase_end) begin
                        state_d = (ROUNDS > 1) ? ST_RUN : ST_DRAIN;
                        main_d  = 5'd0;
                        round_d = 5'd1;
                    end else begin
                        main_d = main_q + 5'd1;
                    end
                end
                ST_RUN: begin
                    if (phase_end) begin
                        main_d = 5'd0;
                        if (round_q == RUN_LAST) begin
                            state_d = ST_DRAIN;
                            round_d = DRAIN_RND;
                        end else begin
                            round_d = round_q + 5'd1;
                        end
                    end else begin
                        main_d = main_q + 5'd1;
                    end
                end
                ST_DRAIN: begin
                    if (phase_end) begin
                        state_d = ST_IDLE;
                        main_d  = 5'd0;
                        round_d = 5'd0;
                    end else begin
                        main_d = main_q + 5'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    main_d  = 5'd0;
                    round_d = 5'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            main_q    <= 5'd0;
            round_q   <= 5'd0;
            key_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            main_q    <= main_d;
            round_q   <= round_d;
            key_err_q <= key_err_d;
        end
    end

    // Round phase 0 is the key load, so subkey bytes only appear from phase 1 on
    assign sk_valid = ((state_q == ST_RUN) || (state_q == ST_DRAIN)) &&
                      (main_q <= SK_LAST) && (round_q != 5'd0);

    assign bus.key_ready     = key_ready;
    assign bus.key_byte      = key_ready ? bus.key_in : 8'h00;
    assign bus.main_counter  = main_q;
    assign bus.round_counter = round_q;
    assign bus.sk_valid      = sk_valid;
    assign bus.sk_round      = sk_valid ? 4'(round_q - 5'd1) : 4'd0;
    assign bus.sk_index      = main_q[1:0];
    assign bus.busy          = (state_q != ST_IDLE);
    assign bus.done          = (state_q == ST_DRAIN) && phase_end;
    assign bus.key_err       = key_err_q;

endmodule

// File: tb/tb_seed_key_sequencer.sv
// Bench for seed_key_sequencer: scenario table, hand-written corner sequences and random
// stimulus, all checked cycle by cycle against a phase-time reference model.
module tb_seed_key_sequencer;

    localparam int PHASE_LEN = 17;
    localparam int ROUNDS    = 16;
    localparam int LAST_T    = (ROUNDS + 1) * PHASE_LEN - 1;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    seed_key_sequencer_if bus ();

    seed_key_sequencer #(.PHASE_LEN(PHASE_LEN), .ROUNDS(ROUNDS)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: one "time since first LOAD cycle" counter instead of a state machine
    bit m_active;
    int m_t;
    bit m_err;

    logic       obs_skv;
    logic [3:0] obs_sr;
    logic [1:0] obs_si;
    logic       obs_done;

    typedef struct {
        string name;
        int    gap_t;
        int    abort_t;
        bit    spam;
        int    exp_done_len;
        int    exp_done_cnt;
        bit    exp_err;
        int    exp_sk;
    } vec_t;

    vec_t vecs[10];

    function automatic vec_t mk(string nm, int gap_t, int abort_t, bit spam,
                                int dl, int dc, bit err, int sk);
        vec_t v;
        v.name = nm; v.gap_t = gap_t; v.abort_t = abort_t; v.spam = spam;
        v.exp_done_len = dl; v.exp_done_cnt = dc; v.exp_err = err; v.exp_sk = sk;
        return v;
    endfunction

    function automatic logic [28:0] dut_out();
        return {bus.key_ready, bus.key_byte, bus.main_counter, bus.round_counter,
                bus.sk_valid, bus.sk_round, bus.sk_index, bus.busy, bus.done, bus.key_err};
    endfunction

    function automatic logic [28:0] model_out(logic [7:0] kin);
        int ph, pos;
        bit kr, skv;
        logic [7:0] kb;
        logic [3:0] sr;
        ph  = m_active ? m_t / PHASE_LEN : 0;
        pos = m_active ? m_t % PHASE_LEN : 0;
        kr  = m_active && (m_t < 16);
        kb  = kr ? kin : 8'h00;
        skv = m_active && (ph >= 1) && (pos <= 3);
        sr  = skv ? 4'(ph - 1) : 4'd0;
        return {kr, kb, 5'(pos), 5'(ph), skv, sr, 2'(pos % 4),
                m_active, (m_active && m_t == LAST_T), m_err};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Entered just after a rising edge; applies inputs, checks at the falling edge, advances model
    task automatic cycle(bit st, bit ab, bit kv, logic [7:0] kin);
        bus.start = st; bus.abort = ab; bus.key_valid = kv; bus.key_in = kin;
        @(negedge clk);
        check("outputs", 32'(dut_out()), 32'(model_out(kin)));
        obs_skv  = bus.sk_valid;
        obs_sr   = bus.sk_round;
        obs_si   = bus.sk_index;
        obs_done = bus.done;
        @(posedge clk);
        if (ab) begin
            m_active = 0; m_t = 0;
        end else if (!m_active) begin
            if (st) begin m_active = 1; m_t = 0; m_err = 0; end
        end else if (m_t < 16 && !kv) begin
            m_err = 1; m_active = 0; m_t = 0;
        end else if (m_t == LAST_T) begin
            m_active = 0; m_t = 0;
        end else begin
            m_t++;
        end
        #1;
    endtask

    task automatic run_vec(vec_t v);
        int done_len, done_cnt, sk_cnt, order_err;
        bit st, ab, kv;
        done_len = -1; done_cnt = 0; sk_cnt = 0; order_err = 0;
        for (int k = 0; k < 300; k++) begin
            st = (k == 0) || (v.spam && k >= 2 && k <= 280 && (k % 3) == 0);
            ab = (v.abort_t >= 0) && (k - 1 == v.abort_t);
            kv = !((v.gap_t >= 0) && (k - 1 == v.gap_t));
            cycle(st, ab, kv, 8'(k - 1));
            if (obs_done) begin
                done_cnt++;
                if (done_len < 0) done_len = k;
            end
            if (obs_skv) begin
                if (obs_sr != 4'(sk_cnt / 4) || obs_si != 2'(sk_cnt % 4)) order_err++;
                sk_cnt++;
            end
        end
        check({v.name, "_done_len"}, done_len, v.exp_done_len);
        check({v.name, "_done_cnt"}, done_cnt, v.exp_done_cnt);
        check({v.name, "_key_err"}, 32'(bus.key_err), 32'(v.exp_err));
        check({v.name, "_sk_count"}, sk_cnt, v.exp_sk);
        check({v.name, "_sk_order"}, order_err, 0);
        check({v.name, "_idle_after"}, 32'(bus.busy), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard, dcnt;
        vecs[0] = mk("nominal",      -1,  -1, 1'b0, 289, 1, 1'b0, 64);
        vecs[1] = mk("start_spam",   -1,  -1, 1'b1, 289, 1, 1'b0, 64);
        vecs[2] = mk("gap_byte6",     5,  -1, 1'b0,  -1, 0, 1'b1,  0);
        vecs[3] = mk("gap_byte1",     0,  -1, 1'b0,  -1, 0, 1'b1,  0);
        vecs[4] = mk("gap_byte16",   15,  -1, 1'b0,  -1, 0, 1'b1,  0);
        vecs[5] = mk("abort_r7_m2",  -1, 121, 1'b0,  -1, 0, 1'b0, 27);
        vecs[6] = mk("abort_load",   -1,   0, 1'b0,  -1, 0, 1'b0,  0);
        vecs[7] = mk("abort_run1",   -1,  17, 1'b0,  -1, 0, 1'b0,  1);
        vecs[8] = mk("abort_drain",  -1, 272, 1'b0,  -1, 0, 1'b0, 61);
        vecs[9] = mk("abort_on_gap",  5,   5, 1'b0,  -1, 0, 1'b0,  0);

        bus.start = 0; bus.abort = 0; bus.key_valid = 0; bus.key_in = 8'h00;
        m_active = 0; m_t = 0; m_err = 0;

        #12;
        check("reset_state", 32'(dut_out()), 0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i]);
            for (int j = 0; j < 3; j++) cycle(0, 0, 1, 8'h00);
        end

        // start and abort together while idle
        cycle(1, 1, 1, 8'hAA);
        check("start_abort_idle", {27'd0, bus.busy, bus.main_counter}, 0);

        // key gap sets key_err, next start clears it, abort returns to idle
        cycle(1, 0, 1, 8'h00);
        for (int i = 0; i < 5; i++) cycle(0, 0, 1, 8'(i));
        cycle(0, 0, 0, 8'h05);
        check("gap_err_set", {30'd0, bus.key_err, bus.busy}, 32'b10);
        cycle(1, 0, 1, 8'h00);
        check("gap_err_cleared", {30'd0, bus.key_err, bus.busy}, 32'b01);
        cycle(0, 1, 1, 8'h00);
        check("abort_counters", {21'd0, bus.busy, bus.main_counter, bus.round_counter}, 0);

        // asynchronous reset in the middle of the drain phase
        cycle(1, 0, 1, 8'h00);
        guard = 0;
        while (m_active && m_t < 16 * PHASE_LEN + 5 && guard < 400) begin
            cycle(0, 0, 1, 8'($urandom));
            guard++;
        end
        check("reached_drain", 32'(bus.round_counter), 32'(ROUNDS));
        #3 reset_n = 1'b0;
        #1 check("async_reset_drain", 32'(dut_out()), 0);
        m_active = 0; m_t = 0; m_err = 0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 30; i++) begin
            cycle(0, 0, 1, 8'h00);
            if (obs_done) dcnt++;
        end
        check("no_done_after_reset", dcnt, 0);

        // random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            cycle(($urandom % 8) == 0, ($urandom % 300) == 0,
                  ($urandom % 40) != 0, 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
